uart_rx_oversample: RTL and testbench

- Standalone UART receiver for the serial line driven by the existing uart transmitter.
- Samples the line at OVERSAMPLE times the baud rate and takes a 3-sample majority vote in the middle of each bit.
- Optional parity check; reports framing and parity errors separately.
- Holds off on a break condition (line held low) until the line returns idle.
- Byte output is an 8-bit value with a one-cycle valid strobe.

---
 rtl/uart_rx_oversample.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// UART receiver with oversampled bit timing and 3-sample majority vote.
// Reports good bytes, framing errors and parity errors as one-clk pulses,
// and holds in a break state while the line is stuck low.
module uart_rx_oversample #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       break_det
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_FIRST   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_WRAP    = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t state, state_n;

  logic          sync1, rxs, rxs_prev;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic          samp0, samp1;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          par_bad;

  logic tick, vote_pt, bit_end, voted, fall;
  logic clr_cnt, shift_en, idx_clr, idx_inc, par_load, stop_load;

  assign tick    = (tcnt == TICK_LAST);
  assign vote_pt = tick && (scnt == S_LAST);
  assign bit_end = tick && (scnt == S_WRAP);
  assign voted   = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
  assign fall    = rxs_prev & ~rxs;

  assign rx_busy   = (state != IDLE);
  assign break_det = (state == BREAK);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_in;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  // Oversample tick divider, per-bit sample counter and the first two vote samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      scnt  <= '0;
      samp0 <= 1'b0;
      samp1 <= 1'b0;
    end else begin
      if (clr_cnt) begin
        tcnt <= '0;
        scnt <= '0;
      end else if (tick) begin
        tcnt <= '0;
        scnt <= (scnt == S_WRAP) ? '0 : scnt + 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (tick && (scnt == S_FIRST)) samp0 <= rxs;
      if (tick && (scnt == S_MID))   samp1 <= rxs;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and datapath controls; stop-bit action happens at mid-bit so a
  // following start edge half a bit later is caught.
  always_comb begin
    state_n   = state;
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    par_load  = 1'b0;
    stop_load = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          clr_cnt = 1'b1;
        end
      end
      START: begin
        if (vote_pt && voted) begin
          state_n = IDLE;
        end else if (bit_end) begin
          state_n = DATA;
          idx_clr = 1'b1;
        end
      end
      DATA: begin
        if (vote_pt) shift_en = 1'b1;
        if (bit_end) begin
          if (bit_idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
          else                 idx_inc = 1'b1;
        end
      end
      PARITY: begin
        if (vote_pt) par_load = 1'b1;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (vote_pt) begin
          stop_load = 1'b1;
          if (!voted && (shift == 8'h00)) begin
            state_n = BREAK;
            clr_cnt = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      BREAK: begin
        if (!rxs)         clr_cnt = 1'b1;
        else if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, parity result, output byte and the registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= 8'h00;
      bit_idx    <= 3'd0;
      par_bad    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (idx_clr) begin
        bit_idx <= 3'd0;
        par_bad <= 1'b0;
      end else if (idx_inc) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) shift <= {voted, shift[7:1]};
      if (par_load) par_bad <= voted ^ (^shift) ^ PARITY_ODD;
      if (stop_load) begin
        rx_data    <= shift;
        rx_valid   <= voted & ~par_bad;
        parity_err <= par_bad;
        frame_err  <= ~voted;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: one default-rate instance, one fast
// instance without parity and one fast instance with even parity.
module tb_uart_rx_oversample;

  localparam int BIT_DEF  = 864;
  localparam int BIT_FAST = 64;

  localparam logic [2:0] K_VALID  = 3'b001;
  localparam logic [2:0] K_FRAME  = 3'b010;
  localparam logic [2:0] K_PARITY = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst_n_par;
  logic line_def, line_fast, line_par;

  logic [7:0] data_def, data_fast, data_par;
  logic valid_def, busy_def, ferr_def, perr_def, brk_def;
  logic valid_fast, busy_fast, ferr_fast, perr_fast, brk_fast;
  logic valid_par, busy_par, ferr_par, perr_par, brk_par;

  exp_t q_def[$];
  exp_t q_fast[$];
  exp_t q_par[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_oversample dut_def (
    .clk(clk), .rst_n(rst_n), .rx_in(line_def),
    .rx_data(data_def), .rx_valid(valid_def), .rx_busy(busy_def),
    .frame_err(ferr_def), .parity_err(perr_def), .break_det(brk_def)
  );

  uart_rx_oversample #(.BAUD_RATE(1_562_500), .OVERSAMPLE(8)) dut_fast (
    .clk(clk), .rst_n(rst_n), .rx_in(line_fast),
    .rx_data(data_fast), .rx_valid(valid_fast), .rx_busy(busy_fast),
    .frame_err(ferr_fast), .parity_err(perr_fast), .break_det(brk_fast)
  );

  uart_rx_oversample #(.BAUD_RATE(1_562_500), .OVERSAMPLE(8),
                       .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_par (
    .clk(clk), .rst_n(rst_n_par), .rx_in(line_par),
    .rx_data(data_par), .rx_valid(valid_par), .rx_busy(busy_par),
    .frame_err(ferr_par), .parity_err(perr_par), .break_det(brk_par)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setLine(input int which, input logic v);
    case (which)
      0:       line_def  = v;
      1:       line_fast = v;
      default: line_par  = v;
    endcase
  endtask

  // Drives one frame: start, 8 data bits LSB first, optional parity bit, stop bit.
  task automatic applyStimulus(input int which, input logic [7:0] data, input bit par_en,
                               input bit par_bit, input bit stop_bit, input int bit_clk);
    setLine(which, 1'b0);
    waitClk(bit_clk);
    for (int i = 0; i < 8; i++) begin
      setLine(which, data[i]);
      waitClk(bit_clk);
    end
    if (par_en) begin
      setLine(which, par_bit);
      waitClk(bit_clk);
    end
    setLine(which, stop_bit);
    waitClk(bit_clk);
  endtask

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin : mon_def
    logic [2:0] k;
    exp_t e;
    k = {perr_def, ferr_def, valid_def};
    if (k != 3'b000) begin
      if (q_def.size() == 0) begin
        checkOutput("def_unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = q_def.pop_front();
        checkOutput("def_kind", 32'(k), 32'(e.kind));
        checkOutput("def_data", 32'(data_def), 32'(e.data));
      end
    end
  end

  // Scoreboard monitor for the fast instance.
  always @(negedge clk) begin : mon_fast
    logic [2:0] k;
    exp_t e;
    k = {perr_fast, ferr_fast, valid_fast};
    if (k != 3'b000) begin
      if (q_fast.size() == 0) begin
        checkOutput("fast_unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = q_fast.pop_front();
        checkOutput("fast_kind", 32'(k), 32'(e.kind));
        checkOutput("fast_data", 32'(data_fast), 32'(e.data));
      end
    end
  end

  // Scoreboard monitor for the parity instance.
  always @(negedge clk) begin : mon_par
    logic [2:0] k;
    exp_t e;
    k = {perr_par, ferr_par, valid_par};
    if (k != 3'b000) begin
      if (q_par.size() == 0) begin
        checkOutput("par_unexpected_pulse", 32'(k), 32'd0);
      end else begin
        e = q_par.pop_front();
        checkOutput("par_kind", 32'(k), 32'(e.kind));
        checkOutput("par_data", 32'(data_par), 32'(e.data));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (150000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cnt;
    rst_n     = 1'b0;
    rst_n_par = 1'b0;
    line_def  = 1'b1;
    line_fast = 1'b1;
    line_par  = 1'b1;
    waitClk(5);

    checkOutput("rst_def_data",  32'(data_def),  32'h0);
    checkOutput("rst_def_valid", 32'(valid_def), 32'h0);
    checkOutput("rst_def_busy",  32'(busy_def),  32'h0);
    checkOutput("rst_def_ferr",  32'(ferr_def),  32'h0);
    checkOutput("rst_def_perr",  32'(perr_def),  32'h0);
    checkOutput("rst_def_brk",   32'(brk_def),   32'h0);
    checkOutput("rst_par_data",  32'(data_par),  32'h0);
    checkOutput("rst_par_busy",  32'(busy_par),  32'h0);

    rst_n     = 1'b1;
    rst_n_par = 1'b1;
    waitClk(20);

    // 8'h55 at the default rate
    q_def.push_back('{kind: K_VALID, data: 8'h55});
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1, BIT_DEF);
    waitClk(100);
    checkOutput("t55_data", 32'(data_def), 32'h55);
    checkOutput("t55_busy", 32'(busy_def), 32'h0);

    // back-to-back frames, no idle gap
    q_def.push_back('{kind: K_VALID, data: 8'hAA});
    q_def.push_back('{kind: K_VALID, data: 8'h0F});
    applyStimulus(0, 8'hAA, 1'b0, 1'b0, 1'b1, BIT_DEF);
    applyStimulus(0, 8'h0F, 1'b0, 1'b0, 1'b1, BIT_DEF);
    waitClk(100);
    checkOutput("b2b_data", 32'(data_def), 32'h0F);

    // 300-clk glitch: busy from detection to the START vote, about 540 clk
    cnt = 0;
    line_def = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_def) cnt++;
    end
    line_def = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (busy_def) cnt++;
    end
    checkOutput("glitch_busy_window", 32'((cnt > 400) && (cnt < BIT_DEF)), 32'd1);
    checkOutput("glitch_data_kept", 32'(data_def), 32'h0F);

    // 8'h3C with low stop bit, then recovery with 8'h81
    q_fast.push_back('{kind: K_FRAME, data: 8'h3C});
    applyStimulus(1, 8'h3C, 1'b0, 1'b0, 1'b0, BIT_FAST);
    line_fast = 1'b1;
    waitClk(2 * BIT_FAST);
    q_fast.push_back('{kind: K_VALID, data: 8'h81});
    applyStimulus(1, 8'h81, 1'b0, 1'b0, 1'b1, BIT_FAST);
    waitClk(BIT_FAST);

    // break: 20 bit times low, then high; break_det falls about one bit after rise
    q_fast.push_back('{kind: K_FRAME, data: 8'h00});
    line_fast = 1'b0;
    waitClk(20 * BIT_FAST);
    checkOutput("brk_det_held", 32'(brk_fast),  32'd1);
    checkOutput("brk_busy_held", 32'(busy_fast), 32'd1);
    line_fast = 1'b1;
    cnt = 0;
    while (brk_fast && (cnt < 5 * BIT_FAST)) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("brk_release_time", 32'((cnt >= 60) && (cnt <= 75)), 32'd1);
    waitClk(BIT_FAST);
    q_fast.push_back('{kind: K_VALID, data: 8'h12});
    applyStimulus(1, 8'h12, 1'b0, 1'b0, 1'b1, BIT_FAST);
    waitClk(BIT_FAST);
    checkOutput("brk_after_busy", 32'(busy_fast), 32'd0);

    // even parity: 8'h07 has three ones so the parity bit must be 1
    q_par.push_back('{kind: K_VALID, data: 8'h07});
    applyStimulus(2, 8'h07, 1'b1, 1'b1, 1'b1, BIT_FAST);
    waitClk(BIT_FAST);
    q_par.push_back('{kind: K_PARITY, data: 8'h07});
    applyStimulus(2, 8'h07, 1'b1, 1'b0, 1'b1, BIT_FAST);
    waitClk(BIT_FAST);
    checkOutput("par_data_updated", 32'(data_par), 32'h07);

    // reset mid-byte: start plus four data bits, then reset with the line idle
    line_par = 1'b0;
    waitClk(BIT_FAST);
    for (int i = 0; i < 4; i++) begin
      line_par = i[0];
      waitClk(BIT_FAST);
    end
    checkOutput("mid_busy_before_rst", 32'(busy_par), 32'd1);
    rst_n_par = 1'b0;
    line_par  = 1'b1;
    waitClk(2);
    checkOutput("mid_rst_data",  32'(data_par),  32'h0);
    checkOutput("mid_rst_busy",  32'(busy_par),  32'h0);
    checkOutput("mid_rst_valid", 32'(valid_par), 32'h0);
    checkOutput("mid_rst_perr",  32'(perr_par),  32'h0);
    checkOutput("mid_rst_brk",   32'(brk_par),   32'h0);
    waitClk(10);
    rst_n_par = 1'b1;
    waitClk(15 * BIT_FAST);
    checkOutput("mid_after_busy", 32'(busy_par), 32'h0);

    // good byte after reset: 8'hA5 has four ones, parity bit 0
    q_par.push_back('{kind: K_VALID, data: 8'hA5});
    applyStimulus(2, 8'hA5, 1'b1, 1'b0, 1'b1, BIT_FAST);
    waitClk(BIT_FAST);

    checkOutput("q_def_left",  32'(q_def.size()),  32'd0);
    checkOutput("q_fast_left", 32'(q_fast.size()), 32'd0);
    checkOutput("q_par_left",  32'(q_par.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
